switch_gate_ctrl: RTL and testbench

// Front-end controller for the 4-input combinational gate block.
// - Synchronises and debounces four raw board switches (chave A..D).
// - Applies each new stable switch vector to the gate's a/b/c/d inputs.
// - Captures the gate output s one settle cycle later.
// - Presents the captured result to downstream logic over a valid/ready handshake.

---
 rtl/switch_gate_ctrl.sv | 123 ++++++++++++
 tb/tb_switch_gate_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_gate_ctrl.sv
// switch_gate_ctrl: front end for a 4-input combinational gate block.
// Raw switches are synchronised and debounced. Each new stable vector is
// driven onto a..d. The gate output s is captured one settle cycle later,
// and the captured value is offered downstream on a valid/ready port.
module switch_gate_ctrl #(
   parameter int DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_raw,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       s,
   output logic       result,
   output logic       result_valid,
   input  logic       result_ready,
   output logic       overrun
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   // IDLE waits for a new stable vector. SETTLE gives the gate one cycle to
   // propagate. CAPTURE samples s. The state is a named signal so checkers
   // can bind to it.
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      sync1, sync2, stable;
   logic [CW-1:0]   cnt [4];
   logic [3:0]      gate_in, gate_in_nxt;
   logic            result_nxt, valid_nxt, overrun_nxt;

   assign {a, b, c, d} = gate_in;

   // Two-flop synchroniser for each raw switch bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: accept a new level after DEB_CYCLES consecutive
   // samples that differ from the accepted level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // State register and registered outputs. Reset enters SETTLE, so the
   // all-zero vector is evaluated once right after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SETTLE;
         gate_in      <= '0;
         result       <= 1'b0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nxt;
         gate_in      <= gate_in_nxt;
         result       <= result_nxt;
         result_valid <= valid_nxt;
         overrun      <= overrun_nxt;
      end
   end

   // Next-state and output logic.
   // Handshake: a transfer happens at any edge where result_valid and
   // result_ready are both high. While result_valid is high and no transfer
   // has occurred, result and result_valid hold steady. A capture at the
   // same edge as a transfer loads the new result and keeps valid high.
   // A capture that replaces an unconsumed result with no transfer at that
   // edge sets the sticky overrun flag. Only rst clears overrun.
   always_comb begin
      state_nxt   = state;
      gate_in_nxt = gate_in;
      result_nxt  = result;
      valid_nxt   = result_valid;
      overrun_nxt = overrun;
      if (result_valid && result_ready) valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (stable != gate_in) begin
               gate_in_nxt = stable;
               state_nxt   = SETTLE;
            end
         end
         SETTLE: begin
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            result_nxt = s;
            valid_nxt  = 1'b1;
            if (result_valid && !result_ready) overrun_nxt = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_switch_gate_ctrl.sv
// Testbench for switch_gate_ctrl. The gate is modelled as s = a&b&c&d.
// A reference model runs in step with the DUT, and all outputs are compared
// every cycle. Directed scenarios are followed by a randomized phase.
module tb_switch_gate_ctrl;

   localparam int DEB = 4;

   logic       clk, rst;
   logic [3:0] sw_raw;
   logic       a, b, c, d, s;
   logic       result, result_valid, result_ready, overrun;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   switch_gate_ctrl #(.DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .sw_raw(sw_raw),
      .a(a), .b(b), .c(c), .d(d), .s(s),
      .result(result), .result_valid(result_valid),
      .result_ready(result_ready), .overrun(overrun)
   );

   assign s = a & b & c & d;

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Debounce rule: a bit accepts the opposite level once the last DEB
   // synchronised samples, all taken after its previous acceptance, differ
   // from the accepted level. The evaluation pipeline is tracked as the
   // number of edges remaining until a capture (0 means waiting).
   logic [3:0] m_sync1, m_sync2, m_stable, m_abcd;
   logic       m_res, m_val, m_ovr;
   int         m_to_cap;
   logic [3:0] hist_q[$];
   int         flip_n[4];

   task automatic model_reset();
      m_sync1 = '0; m_sync2 = '0; m_stable = '0; m_abcd = '0;
      m_res = 1'b0; m_val = 1'b0; m_ovr = 1'b0;
      m_to_cap = 2;
      hist_q.delete();
      for (int b = 0; b < 4; b++) flip_n[b] = 0;
   endtask

   task automatic model_step();
      logic [3:0] new_stable;
      logic       all_diff;
      int         n;
      new_stable = m_stable;
      hist_q.push_back(m_sync2);
      n = hist_q.size();
      for (int b = 0; b < 4; b++) begin
         if (n - flip_n[b] >= DEB) begin
            all_diff = 1'b1;
            for (int j = n - DEB; j < n; j++)
               if (hist_q[j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) begin
               new_stable[b] = ~m_stable[b];
               flip_n[b] = n;
            end
         end
      end
      if (m_to_cap == 1) begin
         if (m_val && !result_ready) m_ovr = 1'b1;
         m_res = (m_abcd == 4'hF);
         m_val = 1'b1;
         m_to_cap = 0;
      end else begin
         if (m_val && result_ready) m_val = 1'b0;
         if (m_to_cap == 2) begin
            m_to_cap = 1;
         end else if (m_stable != m_abcd) begin
            m_abcd = m_stable;
            m_to_cap = 2;
         end
      end
      m_stable = new_stable;
      m_sync2  = m_sync1;
      m_sync1  = sw_raw;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check_eq("abcd",    {a, b, c, d},  m_abcd);
         check_eq("result",  result,        m_res);
         check_eq("valid",   result_valid,  m_val);
         check_eq("overrun", overrun,       m_ovr);
      end
   end

   // ---------------- driver ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; sw_raw = 4'h0; result_ready = 1'b0;
      tick(2);
      #1;
      check_eq("rst_abcd",    {a, b, c, d},  4'h0);
      check_eq("rst_valid",   result_valid,  1'b0);
      check_eq("rst_result",  result,        1'b0);
      check_eq("rst_overrun", overrun,       1'b0);
      tick(1);
      rst = 1'b0;
      chk_en = 1'b1;

      // Zero-vector evaluation after release, then consume it.
      tick(1);
      check_eq("t1_valid_e1", result_valid, 1'b0);
      tick(1);
      check_eq("t1_valid_e2", result_valid, 1'b1);
      check_eq("t1_result",   result,       1'b0);
      result_ready = 1'b1;
      tick(1);
      check_eq("t1_consumed", result_valid, 1'b0);

      // 0000 -> 1111 latency.
      sw_raw = 4'hF;
      tick(6);
      check_eq("t2_abcd_e6", {a, b, c, d}, 4'h0);
      tick(1);
      check_eq("t2_abcd_e7", {a, b, c, d}, 4'hF);
      tick(1);
      check_eq("t2_valid_e8", result_valid, 1'b0);
      tick(1);
      check_eq("t2_valid_e9", result_valid, 1'b1);
      check_eq("t2_result",   result,       1'b1);

      // Short glitch is filtered.
      sw_raw = 4'h0;
      tick(14);
      sw_raw = 4'h8;
      tick(3);
      sw_raw = 4'h0;
      tick(12);
      check_eq("t3_a",       a,            1'b0);
      check_eq("t3_valid",   result_valid, 1'b0);
      check_eq("t3_overrun", overrun,      1'b0);

      // Capture coinciding with accept.
      result_ready = 1'b0;
      sw_raw = 4'hF;
      tick(12);
      check_eq("t5_pre_valid", result_valid, 1'b1);
      sw_raw = 4'h0;
      tick(8);
      result_ready = 1'b1;
      tick(1);
      check_eq("t5_valid",   result_valid, 1'b1);
      check_eq("t5_result",  result,       1'b0);
      check_eq("t5_overrun", overrun,      1'b0);
      tick(1);
      check_eq("t5_consumed", result_valid, 1'b0);

      // Overwrite of an unconsumed result.
      result_ready = 1'b0;
      sw_raw = 4'hF;
      tick(12);
      sw_raw = 4'h9;
      tick(12);
      check_eq("t4_overrun", overrun,      1'b1);
      check_eq("t4_result",  result,       1'b0);
      check_eq("t4_valid",   result_valid, 1'b1);

      // Reset while settling.
      sw_raw = 4'hF;
      tick(7);
      check_eq("t6_abcd_pre", {a, b, c, d}, 4'hF);
      #2 rst = 1'b1;
      #1;
      check_eq("t6_abcd",    {a, b, c, d},  4'h0);
      check_eq("t6_valid",   result_valid,  1'b0);
      check_eq("t6_overrun", overrun,       1'b0);
      sw_raw = 4'h0;
      tick(2);
      rst = 1'b0;
      tick(2);
      check_eq("t6_valid_rel",  result_valid, 1'b1);
      check_eq("t6_result_rel", result,       1'b0);

      // Randomized phase: random vectors, random hold times (including
      // glitches), random consumer back-pressure, and one reset.
      for (int seg = 0; seg < 80; seg++) begin
         int hold;
         if ($urandom_range(0, 1) == 0) sw_raw = 4'($urandom_range(0, 15));
         else sw_raw = sw_raw ^ (4'h1 << $urandom_range(0, 3));
         hold = $urandom_range(1, 12);
         for (int k = 0; k < hold; k++) begin
            result_ready = ($urandom_range(0, 3) != 0);
            tick(1);
         end
         if (seg == 40) begin
            #3 rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
      end
      tick(20);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
